// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor update path.
package bp_pkg;

    // Width of the PC fields held in a queued update entry.
    localparam int unsigned BP_PC_W = 32;

    // Sequential fall-through increment for a 4-byte instruction.
    localparam int unsigned BP_PC_INC = 4;

    // One resolved control-flow outcome waiting to be written into the predictor.
    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic [BP_PC_W-1:0] target;
        logic               taken;
        logic               is_br;
        logic               pred_hit;
        logic               glb;
        logic               loc;
        logic               need_btb;
    } BpUpdEntry_s;

    // The BTB needs a write when a taken instruction either missed in the BTB
    // or was fetched from a different next PC than its real target.
    function automatic logic bp_need_btb(input logic taken_eff,
                                         input logic pred_hit,
                                         input logic next_pc_mismatch);
        return taken_eff & (~pred_hit | next_pc_mismatch);
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; push is ignored when full,
// pop is ignored when empty. Head data is presented combinationally.
module bp_upd_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  T     i_data,
    output logic o_full,
    input  logic i_pop,
    output T     o_data,
    output logic o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;
    T            mem_q [DEPTH];

    // Full when indices match but wrap bits differ; empty when pointers match.
    always_comb begin
        o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        o_empty  = (wr_ptr_q == rd_ptr_q);
        do_push  = i_push & ~o_full;
        do_pop   = i_pop & ~o_empty;
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        o_data   = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/bp_upd_ctrl.sv
// Branch predictor update controller: mispredict detection and redirect,
// buffering of resolved outcomes, per-cycle drain into the predictor write
// ports, and saturating statistics counters.
module bp_upd_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ex_vld,
    input  logic                i_ex_is_br,
    input  logic                i_ex_is_jmp,
    input  logic [PC_WIDTH-1:0] i_ex_pc,
    input  logic [PC_WIDTH-1:0] i_ex_target,
    input  logic                i_ex_taken,
    input  logic                i_ex_pred_hit,
    input  logic                i_ex_pred_glb_taken,
    input  logic                i_ex_pred_loc_taken,
    input  logic [PC_WIDTH-1:0] i_ex_pred_next_pc,
    input  logic                i_flush,
    output logic                o_ex_ready,
    output logic                o_redirect_vld,
    output logic [PC_WIDTH-1:0] o_redirect_pc,
    output logic                o_upd_btb_vld,
    output logic [PC_WIDTH-1:0] o_upd_btb_pc,
    output logic [PC_WIDTH-1:0] o_upd_btb_br_addr,
    output logic                o_upd_pht_vld,
    output logic                o_upd_eval_vld,
    output logic [PC_WIDTH-1:0] o_upd_pht_pc,
    output logic                o_upd_pht_taken,
    output logic                o_upd_pht_pred_glb_taken,
    output logic                o_upd_pht_pred_loc_taken,
    input  logic                i_stat_clr,
    output logic [CNT_WIDTH-1:0] o_br_cnt,
    output logic [CNT_WIDTH-1:0] o_mispred_cnt
);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 acc;
    logic                 taken_eff;
    logic                 mispred;
    logic [PC_WIDTH-1:0]  actual_pc;
    BpUpdEntry_s          push_entry;
    BpUpdEntry_s          head_entry;

    logic                 redirect_vld_q, redirect_vld_d;
    logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
    logic                 btb_vld_q, btb_vld_d;
    logic                 pht_vld_q, pht_vld_d;
    logic                 eval_vld_q, eval_vld_d;
    logic [PC_WIDTH-1:0]  upd_pc_q, upd_pc_d;
    logic [PC_WIDTH-1:0]  upd_addr_q, upd_addr_d;
    logic                 upd_taken_q, upd_taken_d;
    logic                 upd_glb_q, upd_glb_d;
    logic                 upd_loc_q, upd_loc_d;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

    // Ready depends only on the full flag so EX stall has no path from i_ex_*.
    assign o_ex_ready = ~fifo_full;
    assign fifo_pop   = ~fifo_empty;

    // Accept, resolved next PC, mispredict detection and entry construction.
    always_comb begin
        acc        = i_ex_vld & (i_ex_is_br | i_ex_is_jmp) & ~fifo_full & ~i_flush;
        taken_eff  = i_ex_is_jmp | i_ex_taken;
        actual_pc  = taken_eff ? i_ex_target : (i_ex_pc + PC_WIDTH'(BP_PC_INC));
        mispred    = acc & (actual_pc != i_ex_pred_next_pc);
        push_entry = '{
            pc:       BP_PC_W'(i_ex_pc),
            target:   BP_PC_W'(i_ex_target),
            taken:    taken_eff,
            is_br:    i_ex_is_br,
            pred_hit: i_ex_pred_hit,
            glb:      i_ex_pred_glb_taken,
            loc:      i_ex_pred_loc_taken,
            need_btb: bp_need_btb(taken_eff, i_ex_pred_hit, i_ex_pred_next_pc != i_ex_target)
        };
    end

    bp_upd_fifo #(
        .T     (BpUpdEntry_s),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (acc),
        .i_data  (push_entry),
        .o_full  (fifo_full),
        .i_pop   (fifo_pop),
        .o_data  (head_entry),
        .o_empty (fifo_empty)
    );

    // Next state for redirect, drain outputs and saturating counters.
    always_comb begin
        redirect_vld_d = mispred;
        redirect_pc_d  = mispred ? actual_pc : redirect_pc_q;

        btb_vld_d   = fifo_pop & head_entry.need_btb;
        pht_vld_d   = fifo_pop & head_entry.is_br;
        eval_vld_d  = fifo_pop & head_entry.is_br & head_entry.pred_hit;
        upd_pc_d    = upd_pc_q;
        upd_addr_d  = upd_addr_q;
        upd_taken_d = upd_taken_q;
        upd_glb_d   = upd_glb_q;
        upd_loc_d   = upd_loc_q;
        if (fifo_pop) begin
            upd_pc_d    = PC_WIDTH'(head_entry.pc);
            upd_addr_d  = PC_WIDTH'(head_entry.target);
            upd_taken_d = head_entry.taken;
            upd_glb_d   = head_entry.glb;
            upd_loc_d   = head_entry.loc;
        end

        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (i_stat_clr) begin
            br_cnt_d  = '0;
            mis_cnt_d = '0;
        end else begin
            if (acc && !(&br_cnt_q)) begin
                br_cnt_d = br_cnt_q + 1'b1;
            end
            if (mispred && !(&mis_cnt_q)) begin
                mis_cnt_d = mis_cnt_q + 1'b1;
            end
        end
    end

    // Output and counter registers; reset clears every one of them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            redirect_vld_q <= 1'b0;
            redirect_pc_q  <= '0;
            btb_vld_q      <= 1'b0;
            pht_vld_q      <= 1'b0;
            eval_vld_q     <= 1'b0;
            upd_pc_q       <= '0;
            upd_addr_q     <= '0;
            upd_taken_q    <= 1'b0;
            upd_glb_q      <= 1'b0;
            upd_loc_q      <= 1'b0;
            br_cnt_q       <= '0;
            mis_cnt_q      <= '0;
        end else begin
            redirect_vld_q <= redirect_vld_d;
            redirect_pc_q  <= redirect_pc_d;
            btb_vld_q      <= btb_vld_d;
            pht_vld_q      <= pht_vld_d;
            eval_vld_q     <= eval_vld_d;
            upd_pc_q       <= upd_pc_d;
            upd_addr_q     <= upd_addr_d;
            upd_taken_q    <= upd_taken_d;
            upd_glb_q      <= upd_glb_d;
            upd_loc_q      <= upd_loc_d;
            br_cnt_q       <= br_cnt_d;
            mis_cnt_q      <= mis_cnt_d;
        end
    end

    assign o_redirect_vld           = redirect_vld_q;
    assign o_redirect_pc            = redirect_pc_q;
    assign o_upd_btb_vld            = btb_vld_q;
    assign o_upd_btb_pc             = upd_pc_q;
    assign o_upd_btb_br_addr        = upd_addr_q;
    assign o_upd_pht_vld            = pht_vld_q;
    assign o_upd_eval_vld           = eval_vld_q;
    assign o_upd_pht_pc             = upd_pc_q;
    assign o_upd_pht_taken          = upd_taken_q;
    assign o_upd_pht_pred_glb_taken = upd_glb_q;
    assign o_upd_pht_pred_loc_taken = upd_loc_q;
    assign o_br_cnt                 = br_cnt_q;
    assign o_mispred_cnt            = mis_cnt_q;

endmodule

// File: tb/tb_bp_upd_ctrl.sv
// Testbench for bp_upd_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the update path.
module tb_bp_upd_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_vld, is_br, is_jmp, taken, hit, glb, loc, flush, clr;
    logic [31:0] ex_pc, ex_tgt, pnext;

    logic        ex_ready, r_vld, btb_vld, pht_vld, eval_vld, u_taken, u_glb, u_loc;
    logic [31:0] r_pc, btb_pc, btb_addr, pht_pc;
    logic [CW-1:0] br_cnt, mis_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        bit taken, is_br, hit, glb, loc, need;
    } item_t;

    item_t       mq[$];
    bit          pop_blk = 1'b0;
    bit          e_rvld, e_btbv, e_phtv, e_evalv, e_tk, e_glb, e_loc;
    logic [31:0] e_rpc, e_pc, e_addr;
    int          e_br, e_mis;

    bp_upd_ctrl #(.PC_WIDTH(32), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ex_vld(ex_vld), .i_ex_is_br(is_br), .i_ex_is_jmp(is_jmp),
        .i_ex_pc(ex_pc), .i_ex_target(ex_tgt), .i_ex_taken(taken),
        .i_ex_pred_hit(hit), .i_ex_pred_glb_taken(glb), .i_ex_pred_loc_taken(loc),
        .i_ex_pred_next_pc(pnext), .i_flush(flush), .o_ex_ready(ex_ready),
        .o_redirect_vld(r_vld), .o_redirect_pc(r_pc),
        .o_upd_btb_vld(btb_vld), .o_upd_btb_pc(btb_pc), .o_upd_btb_br_addr(btb_addr),
        .o_upd_pht_vld(pht_vld), .o_upd_eval_vld(eval_vld), .o_upd_pht_pc(pht_pc),
        .o_upd_pht_taken(u_taken), .o_upd_pht_pred_glb_taken(u_glb),
        .o_upd_pht_pred_loc_taken(u_loc),
        .i_stat_clr(clr), .o_br_cnt(br_cnt), .o_mispred_cnt(mis_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        e_rvld = 0; e_rpc = '0; e_btbv = 0; e_phtv = 0; e_evalv = 0;
        e_pc = '0; e_addr = '0; e_tk = 0; e_glb = 0; e_loc = 0;
        e_br = 0; e_mis = 0;
    endtask

    task automatic drive(input bit v, input bit b, input bit j, input logic [31:0] pc,
                         input logic [31:0] tg, input bit tk, input bit h, input bit g,
                         input bit l, input logic [31:0] pn, input bit fl, input bit cl);
        ex_vld = v; is_br = b; is_jmp = j; ex_pc = pc; ex_tgt = tg; taken = tk;
        hit = h; glb = g; loc = l; pnext = pn; flush = fl; clr = cl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic check_outputs();
        chk("redirect_vld", r_vld, e_rvld);
        if (e_rvld) chk("redirect_pc", r_pc, e_rpc);
        chk("btb_vld", btb_vld, e_btbv);
        chk("pht_vld", pht_vld, e_phtv);
        chk("eval_vld", eval_vld, e_evalv);
        chk("btb_pc", btb_pc, e_pc);
        chk("pht_pc", pht_pc, e_pc);
        chk("btb_br_addr", btb_addr, e_addr);
        chk("pht_taken", u_taken, e_tk);
        chk("pht_glb", u_glb, e_glb);
        chk("pht_loc", u_loc, e_loc);
        chk("br_cnt", br_cnt, e_br);
        chk("mispred_cnt", mis_cnt, e_mis);
    endtask

    // One clock: predict from spec rules with current inputs, clock, then compare.
    task automatic step();
        bit          rdy, acc, te, mis;
        logic [31:0] act;
        item_t       it;
        rdy = (mq.size() < DEPTH);
        chk("ex_ready", ex_ready, rdy);
        acc = ex_vld && (is_br || is_jmp) && rdy && !flush;
        te  = is_jmp || taken;
        act = te ? ex_tgt : ex_pc + 32'd4;
        mis = acc && (act != pnext);
        e_rvld = mis;
        if (mis) e_rpc = act;
        if (clr) begin
            e_br = 0; e_mis = 0;
        end else begin
            if (acc && e_br < CMAX) e_br++;
            if (mis && e_mis < CMAX) e_mis++;
        end
        if (!pop_blk && mq.size() > 0) begin
            it = mq.pop_front();
            e_btbv = it.need; e_phtv = it.is_br; e_evalv = it.is_br && it.hit;
            e_pc = it.pc; e_addr = it.tgt; e_tk = it.taken; e_glb = it.glb; e_loc = it.loc;
        end else begin
            e_btbv = 0; e_phtv = 0; e_evalv = 0;
        end
        if (acc) begin
            it.pc = ex_pc; it.tgt = ex_tgt; it.taken = te; it.is_br = is_br;
            it.hit = hit; it.glb = glb; it.loc = loc;
            it.need = te && (!hit || pnext != ex_tgt);
            mq.push_back(it);
        end
        @(posedge clk);
        #1;
        check_outputs();
        $display("step t=%0t acc=%0b mis=%0b pc=%h q=%0d btb=%0b pht=%0b eval=%0b br=%0d mis=%0d",
                 $time, acc, mis, ex_pc, mq.size(), btb_vld, pht_vld, eval_vld, br_cnt, mis_cnt);
    endtask

    initial begin
        logic [31:0] rpc, rtg, ractual;
        int          kind;
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", ex_ready, 1);
        check_outputs();
        rst_n = 1'b1;

        // Taken branch, BTB miss: redirect 0x200, then BTB+PHT write.
        drive(1, 1, 0, 32'h100, 32'h200, 1, 0, 0, 0, 32'h104, 0, 0);
        step();
        chk("t1_redirect_pc", r_pc, 32'h200);
        idle();
        step();
        chk("t1_btb_addr", btb_addr, 32'h200);
        chk("t1_mis_cnt", mis_cnt, 1);

        // Not-taken branch correctly predicted.
        drive(1, 1, 0, 32'h40, 32'h999, 0, 1, 1, 0, 32'h44, 0, 0);
        step();
        idle();
        step();
        chk("t2_eval_vld", eval_vld, 1);

        // jal correctly predicted: no redirect, no updates, count only.
        drive(1, 0, 1, 32'h300, 32'h80, 0, 1, 0, 0, 32'h80, 0, 0);
        step();
        idle();
        step();

        // Six back-to-back accepts while draining.
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 8), i[0], i[1], i[0], i[2],
                  32'h1004 + 32'(i * 16), 0, 0);
            step();
        end
        idle();
        repeat (2) step();

        // Drain held off: queue fills after four entries, fifth is refused.
        pop_blk = 1'b1;
        force dut.fifo_pop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 32'h5000 + 32'(i * 4), 32'h6000, 1, 1, 0, 1, 32'h6000, 0, 0);
            step();
        end
        chk("full_ready", ex_ready, 0);
        release dut.fifo_pop;
        pop_blk = 1'b0;
        idle();
        repeat (6) step();

        // Flushed branch: nothing happens.
        drive(1, 1, 0, 32'h700, 32'h800, 1, 0, 0, 0, 32'h704, 1, 0);
        step();
        idle();
        step();

        // Asynchronous reset with three entries queued.
        pop_blk = 1'b1;
        force dut.fifo_pop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'h900 + 32'(i * 4), 32'hA00, 1, 0, 1, 1, 32'h904, 0, 0);
            step();
        end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        release dut.fifo_pop;
        pop_blk = 1'b0;
        model_reset();
        chk("async_rst_ready", ex_ready, 1);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step();

        // Mispredict counter saturation and clear priority.
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 0, 32'hB00, 32'hC00, 1, 1, 0, 0, 32'hB04, 0, 0);
            step();
        end
        chk("sat_mis_cnt", mis_cnt, CMAX);
        drive(1, 1, 0, 32'hB00, 32'hC00, 1, 1, 0, 0, 32'hB04, 0, 1);
        step();
        chk("clr_mis_cnt", mis_cnt, 0);
        idle();
        repeat (2) step();

        // Random traffic including PC wrap near the top of the address space.
        for (int n = 0; n < 300; n++) begin
            rpc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            rtg  = $urandom() & 32'hFFFF_FFFC;
            kind = $urandom_range(0, 9);
            drive($urandom_range(0, 3) != 0, kind < 6, kind >= 6 && kind < 9, rpc, rtg,
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), 32'h0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 31) == 0);
            ractual = (is_jmp || taken) ? rtg : rpc + 32'd4;
            case ($urandom_range(0, 4))
                0, 1:    pnext = ractual;
                2:       pnext = rpc + 32'd4;
                3:       pnext = rtg;
                default: pnext = $urandom();
            endcase
            step();
        end
        idle();
        repeat (DEPTH + 2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bp_upd_ctrl.md
# bp_upd_ctrl

Update controller for the tournament branch predictor. It accepts resolved branch and jump outcomes from EX and detects mispredictions, issuing a registered front-end redirect. Outcomes are buffered in a small FIFO and drained one per cycle into the predictor's BTB, PHT and eval update ports. It also keeps saturating branch and mispredict statistics counters.

## Interface
- PC_WIDTH, 32, PC and target width
- FIFO_DEPTH, 4, update queue entries; power of 2, ≥2
- CNT_WIDTH, 32, statistics counter width
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_ex_vld  in  1  EX holds a valid instruction
- i_ex_is_br / i_ex_is_jmp  in  1 each  conditional branch / jal-jalr
- i_ex_pc, i_ex_target  in  PC_WIDTH  instruction PC, resolved target
- i_ex_taken  in  1  resolved direction (ignored for jumps, treated as 1)
- i_ex_pred_hit, i_ex_pred_glb_taken, i_ex_pred_loc_taken  in  1 each  prediction info carried from fetch
- i_ex_pred_next_pc  in  PC_WIDTH  PC fetched after this instruction
- i_flush  in  1  kill EX instruction this cycle
- o_ex_ready  out  1  queue can accept; EX stalls when low
- o_redirect_vld, o_redirect_pc  out  1, PC_WIDTH  front-end redirect
- o_upd_btb_vld, o_upd_btb_pc, o_upd_btb_br_addr  out  1, PC_WIDTH, PC_WIDTH  BTB write
- o_upd_pht_vld, o_upd_eval_vld, o_upd_pht_pc, o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken  out  1 ×2, PC_WIDTH, 1 ×3  PHT/eval write
- i_stat_clr  in  1  clear counters
- o_br_cnt, o_mispred_cnt  out  CNT_WIDTH  resolved control-flow count, mispredict count

## Operation
- Accept: acc = i_ex_vld & (i_ex_is_br | i_ex_is_jmp) & o_ex_ready & ~i_flush.
- taken_eff = i_ex_is_jmp | i_ex_taken. actual = taken_eff ? i_ex_target : i_ex_pc + 4, wrapping modulo 2^PC_WIDTH.
- mispred = acc & (actual != i_ex_pred_next_pc).
- Redirect: o_redirect_vld <= mispred and o_redirect_pc <= actual. Single-cycle pulse per mispredict.
- Enqueue on acc:
  - fields {pc, target, taken_eff, is_br, pred_hit, glb, loc}
  - need_btb = taken_eff & (~pred_hit | pred_next_pc != target)
- o_ex_ready = ~full. A push is refused when full, even if a pop happens in the same cycle.
- Drain: when not empty, pop the head every cycle into registered outputs:
  - o_upd_btb_vld = need_btb
  - o_upd_pht_vld = is_br
  - o_upd_eval_vld = is_br & pred_hit
  - o_upd_pht_pc = o_upd_btb_pc = pc; o_upd_btb_br_addr = target; o_upd_pht_taken = taken_eff; the glb/loc fields are passed through.
- When empty, all *_vld outputs are 0 and data outputs hold their last value.
- Simultaneous push and pop with the queue non-full: both occur and occupancy is unchanged.
- Pointers wrap at FIFO_DEPTH. Full/empty use an extra wrap bit.
- Counters:
  - o_br_cnt increments on acc; o_mispred_cnt increments on mispred.
  - Both saturate at all-ones.
  - i_stat_clr forces both to 0 and wins over a same-cycle increment.
- i_flush affects only the current EX input. Queued entries still drain.

## Timing
- Reset (async, any cycle): queue emptied, pending updates discarded, all registered outputs 0, counters 0. o_ex_ready = 1.
- Accept in cycle N:
  - redirect visible in N+1
  - counters updated in N+1
  - entry in queue in N+1
  - predictor update pulse in N+2 when the queue was empty
- Each queued entry adds 1 cycle of update latency. Sustained throughput is 1 accept and 1 drain per cycle.
- o_ex_ready is combinational from the full flag only, with no path from i_ex_*.
- Update ports are pure registers: the predictor samples them on the next edge.

## Structure
- Shared bp_pkg holds:
  - BpUpdEntry_s (packed entry struct)
  - the PC + 4 increment constant
  - the need_btb rule as a function
- Sub-module bp_upd_fifo: generic synchronous FIFO parameterized by entry type and depth, async active-low reset, push/pop/full/empty.
- The controller holds the accept/mispredict logic, drain output registers and counters.

## Test plan
- Taken branch, pc 0x100, target 0x200, pred_next 0x104, BTB miss → redirect 0x200 at N+1; at N+2 btb_vld=1 br_addr=0x200, pht_vld=1 taken=1, eval_vld=0; mispred_cnt=1.
- Not-taken branch, pc 0x40, pred_next 0x44, pred_hit=1, glb=1, loc=0 → no redirect; N+2 pht_vld=1 taken=0 eval_vld=1 glb=1 loc=0, btb_vld=0.
- jal pc 0x300 target 0x80, pred_hit=1, pred_next 0x80 → no redirect, btb_vld=0, pht_vld=0, br_cnt+1.
- Accept and drain patterns against FIFO_DEPTH=4:
  - 6 back-to-back accepts while draining → no stall, 6 update pulses in order.
  - With the drain stalled by force-filling the queue, o_ex_ready=0 after 4 entries and the 5th is held.
- i_flush with a valid branch → no enqueue, redirect or count. Reset asserted with 3 entries queued → all vld 0 immediately, queue empty after release.
- Preload mispred_cnt to all-ones via 2^CNT_WIDTH (CNT_WIDTH=4, 16 mispredicts) then 1 more → stays 15; i_stat_clr coincident with mispredict → 0.
